// File: rtl/seg7_scan_counter.sv
// ---------------------------------------------------------------------------
// seg7_scan_counter
//
// Purpose:
//   N-digit BCD up/down counter driving a time-multiplexed 7-segment display.
//   A count prescaler produces the step tick. A free-running scan prescaler
//   walks the digit index. Segments, dp and digit_sel are registered every
//   cycle from the current index and count, so they lag by one clock.
//
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-high
//   en         count enable (gates the count prescaler)
//   up         1 = increment, 0 = decrement (sampled on step cycles)
//   load       parallel load strobe (beats a step in the same cycle)
//   load_val   BCD load value, digit 0 in [3:0]; digits >9 clamp to 9
//   blank_lz   blank leading zeros on digits above digit 0
//   segments   {g,f,e,d,c,b,a}
//   dp         decimal point, lit on digit 0 while the wrap flag is set
//   digit_sel  one-hot common select
//   bcd        current count (never inverted)
//   wrap       one-cycle pulse on overflow/underflow
// ---------------------------------------------------------------------------
module seg7_scan_counter #(
  parameter int DIGITS     = 4,
  parameter int COUNT_DIV  = 1000,
  parameter int SCAN_DIV   = 64,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  blank_lz,
  output logic [6:0]            segments,
  output logic                  dp,
  output logic [DIGITS-1:0]     digit_sel,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  wrap
);

  localparam int CW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CW-1:0] COUNT_LAST = CW'(COUNT_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  logic [CW-1:0]        count_pre;
  logic [SW-1:0]        scan_pre;
  logic [IW-1:0]        scan_idx;
  logic [4*DIGITS-1:0]  bcd_q;
  logic [4*DIGITS-1:0]  bcd_inc;
  logic [4*DIGITS-1:0]  bcd_dec;
  logic [4*DIGITS-1:0]  load_clamped;
  logic                 inc_carry;
  logic                 dec_borrow;
  logic                 wrap_q;
  logic                 wrap_flag;
  logic                 step;

  logic [3:0]           cur_digit;
  logic                 cur_blank;
  logic [6:0]           seg_next;
  logic [6:0]           seg_q;
  logic                 dp_q;
  logic [DIGITS-1:0]    sel_q;

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  assign step = en && (count_pre == COUNT_LAST);

  // Ripple increment; a carry out of the top digit means 99..9 -> 00..0.
  always_comb begin
    bcd_inc   = bcd_q;
    inc_carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (inc_carry) begin
        if (bcd_q[4*i +: 4] == 4'd9) begin
          bcd_inc[4*i +: 4] = 4'd0;
        end else begin
          bcd_inc[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
          inc_carry = 1'b0;
        end
      end
    end
  end

  // Ripple decrement; a borrow out of the top digit means 00..0 -> 99..9.
  always_comb begin
    bcd_dec    = bcd_q;
    dec_borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (dec_borrow) begin
        if (bcd_q[4*i +: 4] == 4'd0) begin
          bcd_dec[4*i +: 4] = 4'd9;
        end else begin
          bcd_dec[4*i +: 4] = bcd_q[4*i +: 4] - 4'd1;
          dec_borrow = 1'b0;
        end
      end
    end
  end

  always_comb begin
    load_clamped = load_val;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_val[4*i +: 4] > 4'd9) load_clamped[4*i +: 4] = 4'd9;
    end
  end

  // Counter core: reset beats load, load beats step. Load also restarts
  // the prescaler so the next step comes a full COUNT_DIV cycles later.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_pre <= '0;
      bcd_q     <= '0;
      wrap_q    <= 1'b0;
      wrap_flag <= 1'b0;
    end else if (load) begin
      count_pre <= '0;
      bcd_q     <= load_clamped;
      wrap_q    <= 1'b0;
      wrap_flag <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (en) begin
        count_pre <= (count_pre == COUNT_LAST) ? '0 : count_pre + CW'(1);
      end
      if (step) begin
        if (up) begin
          bcd_q <= bcd_inc;
          if (inc_carry) begin
            wrap_q    <= 1'b1;
            wrap_flag <= ~wrap_flag;
          end
        end else begin
          bcd_q <= bcd_dec;
          if (dec_borrow) begin
            wrap_q    <= 1'b1;
            wrap_flag <= ~wrap_flag;
          end
        end
      end
    end
  end

  // Free-running scan; ignores en so the display stays lit while paused.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_pre <= '0;
      scan_idx <= '0;
    end else if (scan_pre == SCAN_LAST) begin
      scan_pre <= '0;
      scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + IW'(1);
    end else begin
      scan_pre <= scan_pre + SW'(1);
    end
  end

  // Walk from the top digit down so hi_zero reflects "this digit and all
  // above are zero" when the selected digit is reached.
  always_comb begin
    logic hi_zero;
    hi_zero   = 1'b1;
    cur_digit = 4'd0;
    cur_blank = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (bcd_q[4*i +: 4] != 4'd0) hi_zero = 1'b0;
      if (IW'(i) == scan_idx) begin
        cur_digit = bcd_q[4*i +: 4];
        cur_blank = hi_zero && (i != 0);
      end
    end
    seg_next = (blank_lz && cur_blank) ? 7'h00 : decode(cur_digit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q <= 7'h00;
      dp_q  <= 1'b0;
      sel_q <= '0;
    end else begin
      seg_q <= seg_next;
      dp_q  <= wrap_flag && (scan_idx == '0);
      sel_q <= DIGITS'(1) << scan_idx;
    end
  end

  assign segments  = ACTIVE_LOW ? ~seg_q : seg_q;
  assign dp        = ACTIVE_LOW ? ~dp_q  : dp_q;
  assign digit_sel = ACTIVE_LOW ? ~sel_q : sel_q;
  assign bcd       = bcd_q;
  assign wrap      = wrap_q;

endmodule
